epg_fsm: RTL

EPG_FSM -- requirements
Module: epg_fsm

---
 rtl/epg_fsm.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/epg_fsm.sv
// rtl/epg_fsm.sv - Ethernet frame generator FSM with byte-parallel CRC-32 FCS
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               frame request, sampled only in IDLE
//   dst_addr, src_addr  48-bit MACs, sent MSB byte first, captured with start
//   type_length         16-bit type/length, sent MSB byte first
//   pay_len             payload byte count (1..1500 accepted)
//   pay_data/pay_valid  upstream payload byte stream
//   pay_ready           high in every PAYLOAD cycle (combinational)
//   data, control       registered transmit byte stream and frame-byte flag
//   busy                high from first preamble byte through last IFG cycle
//   done, underrun, len_err  one-cycle status pulses
//   tx_packet_counter   4-bit wrapping count of completed frames

module epg_fsm (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [47:0] dst_addr,
    input  logic [47:0] src_addr,
    input  logic [15:0] type_length,
    input  logic [10:0] pay_len,
    input  logic [7:0]  pay_data,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic [7:0]  data,
    output logic        control,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic        len_err,
    output logic [3:0]  tx_packet_counter
);

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, SFD, DST, SRC, TYPE, PAYLOAD, PAD, FCS, IFG
    } state_t;

    // The state names the byte that will be loaded into data at the next
    // edge, so data/control are registered yet pay_ready lines up with
    // the cycle that chooses the payload byte.
    state_t        state;
    logic [10:0]   cnt;
    logic [10:0]   len;
    logic [111:0]  hdr;
    logic [31:0]   crc;

    // Reflected CRC-32 (0xEDB88320), one byte per call.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign pay_ready = (state == PAYLOAD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= 11'd0;
            len               <= 11'd0;
            hdr               <= 112'd0;
            crc               <= 32'hFFFFFFFF;
            data              <= 8'h00;
            control           <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            underrun          <= 1'b0;
            len_err           <= 1'b0;
            tx_packet_counter <= 4'd0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            len_err  <= 1'b0;
            case (state)
                IDLE: begin
                    data    <= 8'h00;
                    control <= 1'b0;
                    busy    <= 1'b0;
                    if (start) begin
                        if (pay_len != 11'd0 && pay_len <= 11'd1500) begin
                            // First preamble byte goes out on this edge.
                            state   <= PREAMBLE;
                            cnt     <= 11'd1;
                            hdr     <= {dst_addr, src_addr, type_length};
                            len     <= pay_len;
                            crc     <= 32'hFFFFFFFF;
                            data    <= 8'h55;
                            control <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                PREAMBLE: begin
                    data <= 8'h55;
                    if (cnt == 11'd6) begin
                        state <= SFD;
                        cnt   <= 11'd0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                SFD: begin
                    data  <= 8'hD5;
                    state <= DST;
                    cnt   <= 11'd0;
                end
                DST, SRC, TYPE: begin
                    data <= hdr[111:104];
                    hdr  <= {hdr[103:0], 8'h00};
                    crc  <= crc_next(crc, hdr[111:104]);
                    if (state == TYPE && cnt == 11'd1) begin
                        state <= PAYLOAD;
                        cnt   <= 11'd0;
                    end else if (state != TYPE && cnt == 11'd5) begin
                        state <= (state == DST) ? SRC : TYPE;
                        cnt   <= 11'd0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                PAYLOAD: begin
                    if (pay_valid) begin
                        data <= pay_data;
                        crc  <= crc_next(crc, pay_data);
                        if (cnt == len - 11'd1) begin
                            if (len < 11'd46) begin
                                // Pad continues the same byte index up to 45.
                                state <= PAD;
                                cnt   <= cnt + 11'd1;
                            end else begin
                                state <= FCS;
                                cnt   <= 11'd0;
                            end
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end else begin
                        // Starvation: truncate, and this edge already counts
                        // as the first inter-frame-gap cycle.
                        data     <= 8'h00;
                        control  <= 1'b0;
                        underrun <= 1'b1;
                        state    <= IFG;
                        cnt      <= 11'd1;
                    end
                end
                PAD: begin
                    data <= 8'h00;
                    crc  <= crc_next(crc, 8'h00);
                    if (cnt == 11'd45) begin
                        state <= FCS;
                        cnt   <= 11'd0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                FCS: begin
                    data <= ~crc[7:0];
                    crc  <= {8'h00, crc[31:8]};
                    if (cnt == 11'd3) begin
                        state <= IFG;
                        cnt   <= 11'd0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                IFG: begin
                    data    <= 8'h00;
                    control <= 1'b0;
                    // cnt==0 is only reached from FCS, never from underrun.
                    if (cnt == 11'd0) begin
                        done              <= 1'b1;
                        tx_packet_counter <= tx_packet_counter + 4'd1;
                    end
                    if (cnt == 11'd11) begin
                        state <= IDLE;
                        cnt   <= 11'd0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
